mips32_run_controller: RTL and testbench

//   Sequences the single-cycle MIPS32 core: streams a program into instruction memory, releases the core,

---
 rtl/mips32_run_controller.sv | 181 ++++++++++++++++++
 tb/tb_mips32_run_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_run_controller.sv
// Run controller for the single-cycle MIPS32 core: loads a program, runs it, stops on halt or watchdog.
// Optional single-step support is compiled in when MIPS_RUN_CTRL_STEP_EN is defined.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | core stopped, waiting for start
//   LOAD   | streaming loader words into instruction memory
//   RUN    | core enabled, cycles counted, halt word and watchdog monitored
//   HALTED | run finished; count and timeout held until the next start
module mips32_run_controller #(
    parameter int unsigned ADDR_W     = 8,
    parameter logic [31:0] HALT_WORD  = 32'h0000000C,
    parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   load_len,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic [31:0]       instruction,
`ifdef MIPS_RUN_CTRL_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_en,
    output logic              pc_clear,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LEN_MAX = LEN_ONE << ADDR_W;
    localparam logic [31:0]     WDOG_LAST = MAX_CYCLES - 32'd1;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              core_en_q, core_en_d;

    logic launch;
    logic accept;
    logic last_word;
    logic run_cycle;
    logic halt_hit;
    logic wdog_hit;
    logic step_ok;

    assign launch    = (state_q == S_IDLE || state_q == S_HALTED) && start && !abort;
    assign accept    = (state_q == S_LOAD) && ld_valid;
    assign last_word = ({1'b0, waddr_q} == (len_q - LEN_ONE));
    // A cycle only counts (and is only checked for halt/watchdog) when the core actually advanced.
    assign run_cycle = (state_q == S_RUN) && core_en_q;
    assign halt_hit  = run_cycle && (instruction == HALT_WORD);
    assign wdog_hit  = run_cycle && (MAX_CYCLES != 32'd0) && (cnt_q == WDOG_LAST);

`ifdef MIPS_RUN_CTRL_STEP_EN
    logic step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_ok = !step_mode || (step && !step_q);
`else
    assign step_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_d = (load_len == '0) ? S_RUN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept && last_word) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt_hit || wdog_hit) begin
                        state_d = S_HALTED;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        len_d = len_q;
        if (launch) begin
            len_d = (load_len > LEN_MAX) ? LEN_MAX : load_len;
        end
    end

    // The address holds on the last word so a full 2**ADDR_W load never wraps to 0.
    always_comb begin
        waddr_d = waddr_q;
        if (launch) begin
            waddr_d = '0;
        end else if (accept && !last_word) begin
            waddr_d = waddr_q + 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (launch) begin
            cnt_d = '0;
        end else if (run_cycle && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if (abort || launch) begin
            timeout_d = 1'b0;
        end else if (wdog_hit && !halt_hit) begin
            timeout_d = 1'b1;
        end
    end

    assign core_en_d = (state_d == S_RUN) && step_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            waddr_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            core_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            waddr_q   <= waddr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            core_en_q <= core_en_d;
        end
    end

    assign ld_ready    = (state_q == S_LOAD);
    assign imem_we     = accept;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = ld_data;
    assign core_en     = core_en_q;
    assign pc_clear    = launch;
    assign busy        = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done        = (state_q == S_HALTED);
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_mips32_run_controller.sv
// Bench for mips32_run_controller: a toy core (PC + instruction memory) plus write/result scoreboards.
// Also exercises single-step when MIPS_RUN_CTRL_STEP_EN is defined.
module tb_mips32_run_controller;

    localparam logic [31:0] HALT = 32'h0000000C;
    localparam logic [31:0] LOOP = 32'h21080001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [8:0]  load_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready, imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] instruction;
    logic        core_en, pc_clear, busy, done, timeout;
    logic [31:0] cycle_count;
`ifdef MIPS_RUN_CTRL_STEP_EN
    logic        step_mode, step;
`endif

    always #5 clk = ~clk;

    mips32_run_controller #(.ADDR_W(8), .HALT_WORD(HALT), .MAX_CYCLES(32'd50)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .instruction(instruction),
`ifdef MIPS_RUN_CTRL_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .ld_ready(ld_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_en(core_en), .pc_clear(pc_clear), .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    // Toy core: PC cleared by pc_clear, advanced by core_en; fetches from bench memory or a preload pattern.
    logic [31:0] tb_mem [256];
    logic [7:0]  pc = 8'd0;
    logic        preload = 1'b0;
    int          halt_at = -1;

    always @(posedge clk) begin
        if (imem_we) tb_mem[imem_waddr] <= imem_wdata;
        if (pc_clear) pc <= 8'd0;
        else if (core_en) pc <= pc + 8'd1;
    end

    assign instruction = preload ? ((int'(pc) == halt_at) ? HALT : LOOP) : tb_mem[pc];

    typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic to; logic [31:0] cnt; } res_t;
    wr_t  wr_q[$];
    res_t res_q[$];

    int   errors = 0;
    int   checks = 0;
    int   en_cycles = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sample();
        wr_t  w;
        res_t r;
        if (imem_we) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 64'(imem_waddr), 64'hFFFF);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", 64'(imem_waddr), 64'(w.addr));
                chk("wr_data", 64'(imem_wdata), 64'(w.data));
            end
        end
        if (ld_ready) chk("ld_ready_only_in_load", 64'({busy, core_en, done}), 64'b100);
        if (core_en) en_cycles++;
        if (done && !done_prev) begin
            if (res_q.size() == 0) begin
                chk("done_unexpected", 64'(done), 64'(0));
            end else begin
                r = res_q.pop_front();
                chk("res_timeout", 64'(timeout), 64'(r.to));
                chk("res_count", 64'(cycle_count), 64'(r.cnt));
                chk("res_en_cycles", 64'(en_cycles), 64'(r.cnt));
            end
        end
        done_prev = done;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic launch_run(input logic [8:0] len, input logic push, input logic to, input logic [31:0] cnt);
        res_t r;
        start = 1'b1;
        load_len = len;
        #1;
        chk("pc_clear_on_start", 64'(pc_clear), 64'(1));
        if (push) begin
            r.to = to;
            r.cnt = cnt;
            res_q.push_back(r);
        end
        en_cycles = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        wr_q.push_back(w);
        ld_valid = 1'b1;
        ld_data = data;
        tick();
        ld_valid = 1'b0;
        ld_data = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) begin
            chk("wait_done_expired", 64'(done), 64'(1));
            res_q.delete();
        end else begin
            tick();
        end
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h20080005;
        prog[1] = 32'h21080001;
        prog[2] = HALT;
        prog[3] = 32'h00000000;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_len = '0;
        ld_valid = 1'b0; ld_data = '0;
`ifdef MIPS_RUN_CTRL_STEP_EN
        step_mode = 1'b0; step = 1'b0;
`endif
        #3;
        chk("reset_ctrl", 64'({ld_ready, imem_we, core_en, pc_clear, busy, done, timeout}), 64'(0));
        chk("reset_waddr", 64'(imem_waddr), 64'(0));
        chk("reset_count", 64'(cycle_count), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Three-word load with ld_valid held high; halts after 3 RUN cycles.
        launch_run(9'd3, 1'b1, 1'b0, 32'd3);
        for (int i = 0; i < 3; i++) begin
            wr_t w;
            w.addr = 8'(i);
            w.data = prog[i];
            wr_q.push_back(w);
            ld_valid = 1'b1;
            ld_data = prog[i];
            tick();
        end
        ld_valid = 1'b0;
        chk("run_after_load", 64'({busy, core_en}), 64'b11);
        wait_done(20);
        chk("t1_done", 64'(done), 64'(1));
        chk("t1_core_en_low", 64'(core_en), 64'(0));

        // Same load with ld_valid toggling every other cycle.
        launch_run(9'd3, 1'b1, 1'b0, 32'd3);
        for (int i = 0; i < 3; i++) begin
            send_word(8'(i), prog[i]);
            if (i < 2) tick();
        end
        chk("t2_writes_drained", 64'(wr_q.size()), 64'(0));
        wait_done(20);

        // Resident program with no halt: watchdog stops it after 50 cycles.
        preload = 1'b1;
        halt_at = -1;
        launch_run(9'd0, 1'b1, 1'b1, 32'd50);
        chk("t3_no_load", 64'({ld_ready, core_en}), 64'b01);
        wait_done(80);
        chk("t3_core_en_after", 64'(core_en), 64'(0));
        tick();
        chk("t3_count_held", 64'(cycle_count), 64'(50));
        chk("t3_timeout_held", 64'(timeout), 64'(1));

        // Halt word on the very cycle the watchdog limit is reached: halt wins.
        halt_at = 49;
        launch_run(9'd0, 1'b1, 1'b0, 32'd50);
        wait_done(80);

        // abort together with start on the second RUN cycle.
        halt_at = -1;
        launch_run(9'd0, 1'b0, 1'b0, 32'd0);
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("t4_state_idle", 64'({busy, done, core_en, timeout}), 64'(0));
        chk("t4_count_held", 64'(cycle_count), 64'(2));
        chk("t4_en_cycles", 64'(en_cycles), 64'(2));
        tick();
        chk("t4_start_ignored", 64'(busy), 64'(0));

        // Reset pulse mid-LOAD after one of four words, then a full reload from address 0.
        preload = 1'b0;
        launch_run(9'd4, 1'b0, 1'b0, 32'd0);
        send_word(8'd0, 32'h11111111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ctrl", 64'({ld_ready, imem_we, core_en, pc_clear, busy, done, timeout}), 64'(0));
        chk("t5_rst_waddr", 64'(imem_waddr), 64'(0));
        chk("t5_rst_count", 64'(cycle_count), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        launch_run(9'd4, 1'b1, 1'b0, 32'd4);
        send_word(8'd0, prog[0]);
        send_word(8'd1, prog[1]);
        send_word(8'd2, 32'h21080002);
        send_word(8'd3, HALT);
        wait_done(20);

        // Oversized load_len clamps to 256 words; addresses 0..255 exactly once, then watchdog.
        launch_run(9'h1FF, 1'b1, 1'b1, 32'd50);
        for (int i = 0; i < 256; i++) begin
            wr_t w;
            w.addr = 8'(i);
            w.data = 32'h21080000 | 32'(i);
            wr_q.push_back(w);
            ld_valid = 1'b1;
            ld_data = w.data;
            tick();
        end
        ld_valid = 1'b0;
        chk("clamp_in_run", 64'({busy, core_en, ld_ready}), 64'b110);
        wait_done(80);
        chk("clamp_writes_drained", 64'(wr_q.size()), 64'(0));

`ifdef MIPS_RUN_CTRL_STEP_EN
        // Single-step: three step pulses give exactly three enabled cycles.
        preload = 1'b1;
        halt_at = 4;
        step_mode = 1'b1;
        launch_run(9'd0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
            tick();
        end
        chk("step_en_cycles", 64'(en_cycles), 64'(3));
        chk("step_count", 64'(cycle_count), 64'(3));
        chk("step_still_run", 64'({busy, done}), 64'b10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        step_mode = 1'b0;
        tick();
`endif

        chk("results_drained", 64'(res_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
